product_accumulator: RTL
========================

# product_accumulator

Downstream stage of the 2x2 array multiplier. Accepts its 4-bit products over a valid/ready handshake and sums a fixed-length frame of `COUNT` products. Presents each frame sum, plus an overflow flag, on a valid/ready output port. Gives the combinational multiplier a sequential dot-product/MAC back end.

## Interface
- `ACC_W`, default 8: accumulator and output sum width; legal range 4..16.
- `COUNT`, default 4: products per frame; legal range 1..255.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: `in_prod` holds a valid product.
- `in_ready`, out, 1: block can accept a product this cycle.
- `in_prod`, in, 4: unsigned product P[3:0] from the multiplier.
- `out_valid`, out, 1: `out_sum`/`out_ovf` hold a completed frame.
- `out_ready`, in, 1: consumer accepts the frame this cycle.
- `out_sum`, out, ACC_W: frame sum.
- `out_ovf`, out, 1: sum exceeded 2^ACC_W−1 during the frame (sticky within the frame).

## Operation
- A beat is accepted when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- FSM states:
  - ACCUM (reset state):
    - `in_ready`=1.
    - On each accepted beat: acc ← acc + `in_prod`, beat count +1.
    - On the COUNT-th accepted beat: go to HOLD.
  - HOLD:
    - `in_ready`=0 and `out_valid`=1.
    - `out_sum` and `out_ovf` are stable until transfer.
    - On transfer: clear acc, ovf and beat count, then go to ACCUM.
- Arithmetic: unsigned. Each addition is computed at ACC_W+1 bits; a set carry sets the ovf flag.
  - Default (no macro): the sum wraps modulo 2^ACC_W.
- `in_valid` gaps in ACCUM: acc and count hold.
- `out_ready` held low in HOLD: the block stalls indefinitely with outputs stable.
- `in_valid` high while in HOLD: no beat is taken. Upstream must hold its data (standard valid/ready rule).
- Reset asserted at any time, including mid-frame or in HOLD:
  - state ACCUM, acc=0, count=0, ovf=0.
  - `out_valid`=0, `out_sum`=0, `out_ovf`=0, `in_ready`=1 after release.
  - A partial frame is discarded.
- `in_prod` values >9 cannot come from a 2x2 multiplier. They are still summed as-is; no check is made.

## Timing
- `in_ready` and `out_valid` are decoded from registered state only; no combinational path from `out_ready` to `in_ready`.
- Latency: `out_valid` rises on the clock edge that accepts the COUNT-th beat. It is visible the cycle after that beat.
- Throughput: one frame per COUNT+1 cycles at best (COUNT input beats + 1 HOLD cycle with `out_ready`=1).
- First beat of the next frame can be accepted the cycle after the output transfer.
- `out_sum`/`out_ovf` are registered. Their values outside HOLD are don't-care for consumers but are driven to 0 after reset.

## Configuration
- `PRODUCT_ACC_SATURATE_EN` defined: on overflow, acc clamps to 2^ACC_W−1 and stays there for the rest of the frame. `out_ovf` is still set.
- Not defined: wrap-around as in Operation; `out_ovf` is still set.
- No other behaviour or timing changes.

## Structure
- Shared package `product_acc_pkg` holds:
  - the FSM state typedef (ACCUM, HOLD);
  - `PROD_W`=4;
  - the beat-counter width constant, 8 bits.
- One sub-module, `beat_counter`:
  - clear and increment inputs;
  - asserts `last` when count == COUNT−1 and increment is asserted;
  - asynchronous active-low reset.
- Top level contains the FSM, accumulator, ovf flag and the saturate/wrap logic.

## Test plan
- Reset, then frame 9,4,1,0 (COUNT=4, ACC_W=8), `out_ready`=1 → `out_valid` the cycle after beat 4, `out_sum`=14, `out_ovf`=0, `in_ready` returns to 1 the next cycle.
- Inputs 3,3 with a 3-cycle `in_valid` gap, then 3,3 → `out_sum`=12; acc and count unchanged during the gap.
- Backpressure: complete a frame with `out_ready`=0 for 5 cycles and `in_valid` held high with `in_prod`=9 → `in_ready`=0 and `out_sum` stable throughout. The held beat is accepted as the first beat of the next frame after the transfer.
- Overflow, ACC_W=5, COUNT=4, inputs 9,9,9,9:
  - without macro → `out_sum`=4, `out_ovf`=1;
  - with `PRODUCT_ACC_SATURATE_EN` → `out_sum`=31, `out_ovf`=1.
  - The following frame 1,1,1,1 → `out_sum`=4, `out_ovf`=0 (flag cleared).
- Reset asserted asynchronously after 2 of 4 beats (values 9,9) → outputs zero immediately. After release, frame 1,2,3,4 → `out_sum`=10 (no residue from the old frame).
- COUNT=1: each beat produces a frame; products 4 then 9 with `out_ready`=1 → `out_sum` 4 then 9, one frame per 2 cycles.

Source files
------------

// File: rtl/product_acc_pkg.sv
// Shared types and constants for the product accumulator slice.
package product_acc_pkg;

  localparam int PROD_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/beat_counter.sv
// Counts accepted beats within a frame; flags the beat that completes it.
module beat_counter
  import product_acc_pkg::*;
#(
  parameter int COUNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic incr,
  output logic last
);

  logic [CNT_W-1:0] count_r;

  assign last = incr && (count_r == CNT_W'(COUNT - 1));

  // Beat count register; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (incr) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT multiplier products per frame and presents the sum over valid/ready.
// Optional feature macro: PRODUCT_ACC_SATURATE_EN (clamp instead of wrap on overflow).
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  acc_state_t       state_r;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;

  logic             accept_s;
  logic             transfer_s;
  logic             last_s;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] acc_next_s;
  logic             ovf_next_s;

  // Handshake strobes come only from registered state, never from out_ready into in_ready.
  assign in_ready   = (state_r == ACCUM);
  assign out_valid  = (state_r == HOLD);
  assign accept_s   = in_valid && (state_r == ACCUM);
  assign transfer_s = out_ready && (state_r == HOLD);

  // The accumulator doubles as the output register, so the sum is stable throughout HOLD.
  assign out_sum = acc_r;
  assign out_ovf = ovf_r;

  beat_counter #(
    .COUNT(COUNT)
  ) u_beat_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(transfer_s),
    .incr (accept_s),
    .last (last_s)
  );

  // Next accumulator value with carry detection; wrap or clamp on overflow.
  always_comb begin
    sum_s      = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    ovf_next_s = ovf_r | sum_s[ACC_W];
`ifdef PRODUCT_ACC_SATURATE_EN
    if (ovf_next_s) begin
      acc_next_s = {ACC_W{1'b1}};
    end else begin
      acc_next_s = sum_s[ACC_W-1:0];
    end
`else
    acc_next_s = sum_s[ACC_W-1:0];
`endif
  end

  // Frame FSM with accumulator and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACCUM;
      acc_r   <= {ACC_W{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            acc_r <= acc_next_s;
            ovf_r <= ovf_next_s;
            if (last_s) begin
              state_r <= HOLD;
            end else begin
              state_r <= ACCUM;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc_r   <= {ACC_W{1'b0}};
            ovf_r   <= 1'b0;
            state_r <= ACCUM;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          acc_r   <= {ACC_W{1'b0}};
          ovf_r   <= 1'b0;
          state_r <= ACCUM;
        end
      endcase
    end
  end

endmodule
